// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds the 10-bit symbol boundary in an unaligned
// deserialized stream using control tokens, then decodes data or control.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS   = 64,
  parameter int SEARCH_CYCLES = 2048,
  parameter int LOSS_CYCLES   = 4096
) (
  input  logic       video_clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam int MAX_CYCLES = (SEARCH_CYCLES > LOSS_CYCLES) ? SEARCH_CYCLES : LOSS_CYCLES;
  localparam int TMR_W      = $clog2(MAX_CYCLES) + 1;
  localparam int RUN_W      = $clog2(LOCK_TOKENS + 1);

  localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOSS_LAST   = TMR_W'(LOSS_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(LOCK_TOKENS);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [9:0]       din_q;
  logic [9:0]       sym;
  logic             slip_q, slip_next;
  logic [RUN_W-1:0] run_cnt, run_inc, run_next;
  logic [TMR_W-1:0] tmr, tmr_next;
  logic [3:0]       offset_next;

  logic [19:0]      win;
  logic [9:0]       aligned;
  logic             tok_raw, tok;
  logic [1:0]       tok_ctrl;
  logic [7:0]       q, dec;
  logic [7:0]       data_next;
  logic [1:0]       ctrl_next;
  logic             de_next;

  // din_q holds the earlier word, so its bit 0 is the oldest serial bit in the window.
  assign win = {din, din_q};

  // NOTE: every signal assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    aligned = win[9:0];
    for (int i = 1; i < 10; i++) begin
      if (bit_offset == 4'(i)) aligned = win[i +: 10];
    end
  end

  always_comb begin
    tok_raw  = 1'b1;
    tok_ctrl = 2'b00;
    case (sym)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        tok_raw  = 1'b0;
    endcase
  end

  // The symbol latched just before a slip was cut at the old offset: never count it.
  assign tok = tok_raw && !slip_q;

  always_comb begin
    q      = sym[9] ? ~sym[7:0] : sym[7:0];
    dec    = 8'h00;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  assign run_inc = tok ? ((run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1) : '0;

  // State register plus the alignment/timing state it owns.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SEARCH;
      tmr        <= '0;
      run_cnt    <= '0;
      bit_offset <= 4'd0;
      slip_q     <= 1'b0;
    end else begin
      state      <= state_next;
      tmr        <= tmr_next;
      run_cnt    <= run_next;
      bit_offset <= offset_next;
      slip_q     <= slip_next;
    end
  end

  // Next-state logic: lock wins over an offset slip in the same cycle.
  always_comb begin
    state_next  = state;
    tmr_next    = tmr + 1'b1;
    run_next    = run_inc;
    offset_next = bit_offset;
    slip_next   = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (run_inc == RUN_MAX) begin
          state_next = ST_LOCKED;
          tmr_next   = '0;
          run_next   = '0;
        end else if (tmr == SEARCH_LAST) begin
          offset_next = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
          tmr_next    = '0;
          run_next    = '0;
          slip_next   = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (tok) begin
          tmr_next = '0;
        end else if (tmr == LOSS_LAST) begin
          state_next = ST_SEARCH;
          tmr_next   = '0;
          run_next   = '0;
        end
      end
      default: state_next = ST_SEARCH;
    endcase
  end

  // Output logic: gated on the state being entered so lock and first output coincide.
  always_comb begin
    data_next = 8'h00;
    ctrl_next = 2'b00;
    de_next   = 1'b0;
    if (state_next == ST_LOCKED) begin
      if (tok) begin
        ctrl_next = tok_ctrl;
      end else begin
        data_next = dec;
        de_next   = 1'b1;
      end
    end
  end

  // NOTE: the datapath registers are reset too, so outputs are defined zero from reset onwards.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q    <= 10'd0;
      sym      <= 10'd0;
      data_out <= 8'h00;
      ctrl_out <= 2'b00;
      de_out   <= 1'b0;
    end else begin
      din_q    <= din;
      sym      <= aligned;
      data_out <= data_next;
      ctrl_out <= ctrl_next;
      de_out   <= de_next;
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: directed scenarios plus random
// blanking/active traffic at random serial phase, checked every cycle by a model.
module tb_tmds_channel_decoder;

  localparam int LT = 8;
  localparam int SC = 32;
  localparam int LC = 64;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;

  logic       video_clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       locked;
  logic [3:0] bit_offset;

  int n_tests = 0;
  int n_fail  = 0;

  // Serial stream generator state: phase of symbol boundaries within each word.
  int         s_shift;
  logic [9:0] s_prev;

  // Reference model state.
  logic [9:0] m_prev, m_sym;
  logic       m_slip, m_locked, m_de;
  int         m_run, m_tmr, m_off;
  logic [1:0] m_ctrl;
  logic [7:0] m_data;

  tmds_channel_decoder #(
    .LOCK_TOKENS  (LT),
    .SEARCH_CYCLES(SC),
    .LOSS_CYCLES  (LC)
  ) dut (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .din       (din),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .de_out    (de_out),
    .locked    (locked),
    .bit_offset(bit_offset)
  );

  always #5 video_clk = ~video_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int token_code(input logic [9:0] s);
    case (s)
      TOK00:   return 0;
      TOK01:   return 1;
      TOK10:   return 2;
      TOK11:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] qv, d;
    qv   = s[9] ? ~s[7:0] : s[7:0];
    d    = 8'h00;
    d[0] = qv[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (qv[i] ^ qv[i-1]) : ~(qv[i] ^ qv[i-1]);
    return d;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_sym = '0; m_slip = 1'b0; m_locked = 1'b0; m_de = 1'b0;
    m_run = 0; m_tmr = 0; m_off = 0; m_ctrl = '0; m_data = '0;
  endtask

  // Advances the model by one clock given the word presented at that edge.
  task automatic model_step(input logic [9:0] w);
    int         c, run_n, tmr_n, off_n;
    logic       tok, lock_n, slip_n;
    logic [9:0] sym_n;
    c      = token_code(m_sym);
    tok    = (c >= 0) && !m_slip;
    run_n  = tok ? ((m_run < LT) ? m_run + 1 : LT) : 0;
    tmr_n  = m_tmr + 1;
    off_n  = m_off;
    lock_n = m_locked;
    slip_n = 1'b0;
    if (!m_locked) begin
      if (run_n == LT) begin
        lock_n = 1'b1; tmr_n = 0; run_n = 0;
      end else if (m_tmr == SC - 1) begin
        off_n = (m_off + 1) % 10; tmr_n = 0; run_n = 0; slip_n = 1'b1;
      end
    end else begin
      if (tok) tmr_n = 0;
      else if (m_tmr == LC - 1) begin
        lock_n = 1'b0; tmr_n = 0; run_n = 0;
      end
    end
    // Ten consecutive serial bits starting m_off bits into the older word.
    for (int i = 0; i < 10; i++)
      sym_n[i] = (m_off + i < 10) ? m_prev[m_off + i] : w[m_off + i - 10];
    m_data = (lock_n && !tok) ? tmds_decode(m_sym) : 8'h00;
    m_ctrl = (lock_n && tok) ? 2'(c) : 2'b00;
    m_de   = lock_n && !tok;
    m_sym = sym_n; m_prev = w; m_slip = slip_n;
    m_run = run_n; m_tmr = tmr_n; m_off = off_n; m_locked = lock_n;
  endtask

  task automatic tick(input logic [9:0] w);
    din = w;
    @(posedge video_clk);
    #1;
    model_step(w);
    check("model", {locked, bit_offset, de_out, ctrl_out, data_out},
          {m_locked, 4'(m_off), m_de, m_ctrl, m_data});
  endtask

  // Emits one symbol into the serial stream at the current phase.
  task automatic send(input logic [9:0] s);
    logic [19:0] tmp;
    tmp    = {s, s_prev} >> (10 - s_shift);
    s_prev = s;
    tick(tmp[9:0]);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 10'($urandom);
      @(posedge video_clk);
      #1;
      check("reset_outputs", {data_out, ctrl_out, de_out, locked, bit_offset}, '0);
    end
    model_reset();
    s_prev = '0;
    rst_n  = 1'b1;
  endtask

  task automatic send_until_locked(input logic [9:0] s, input int limit, output int n);
    n = -1;
    for (int t = 1; t <= limit; t++) begin
      send(s);
      if (locked) begin
        n = t;
        break;
      end
    end
  endtask

  initial begin
    int         n, first_one, wrap, t7;
    logic       saw_lock;
    logic [10:0] obs[7];
    logic [9:0] seq[7];

    rst_n = 1'b0; din = '0; s_shift = 0; s_prev = '0;
    model_reset();
    apply_reset();

    // Offset sweep with no tokens present.
    first_one = -1; wrap = -1; saw_lock = 1'b0;
    for (int t = 1; t <= 330; t++) begin
      send(10'h100);
      if (bit_offset == 4'd1 && first_one < 0) first_one = t;
      if (bit_offset == 4'd0 && t > SC && wrap < 0) wrap = t;
      if (locked) saw_lock = 1'b1;
    end
    check("slip_0_to_1_edge", first_one, SC);
    check("wrap_9_to_0_edge", wrap, 10 * SC);
    check("no_false_lock", saw_lock, 1'b0);

    // Aligned lock: 8 tokens counted, first reaches the counter 2 edges after entry.
    apply_reset();
    send_until_locked(TOK00, 50, n);
    check("aligned_lock_edge", n, LT + 2);
    check("aligned_lock_outs", {ctrl_out, de_out, bit_offset}, '0);

    // Decode: each symbol appears on the outputs two edges after it is sent.
    seq = '{10'h100, 10'h2FF, 10'h3FF, 10'h0FF, TOK11, TOK00, TOK00};
    for (int k = 0; k < 7; k++) begin
      send(seq[k]);
      obs[k] = {de_out, ctrl_out, data_out};
    end
    check("dec_100", obs[2], {1'b1, 2'b00, 8'h00});
    check("dec_2FF", obs[3], {1'b1, 2'b00, 8'hFE});  // q=0x00, XNOR chain sets d[7:1]
    check("dec_3FF", obs[4], {1'b1, 2'b00, 8'h00});
    check("dec_0FF", obs[5], {1'b1, 2'b00, 8'hFF});
    check("dec_tok11", obs[6], {1'b0, 2'b11, 8'h00});

    // Shifted lock: boundary sits 7 bits into each word.
    apply_reset();
    s_shift = 7;
    t7 = -1; n = -1;
    for (int t = 1; t <= 400; t++) begin
      send(TOK00);
      if (bit_offset == 4'd7 && t7 < 0) t7 = t;
      if (locked) begin
        n = t;
        break;
      end
    end
    check("shift_offset7_edge", t7, 7 * SC);
    check("shift_lock_edge", n, 7 * SC + LT + 1);
    for (int k = 0; k < 3; k++) send(10'h0FF);
    check("shift_data_ff", {de_out, data_out}, {1'b1, 8'hFF});

    // Loss: last token is decoded two edges later, then 64 silent edges.
    send(TOK00);
    n = -1;
    for (int t = 1; t <= 200; t++) begin
      send(10'h100);
      if (!locked) begin
        n = t;
        break;
      end
    end
    check("loss_edge", n, 2 + LC);
    check("loss_offset_kept", bit_offset, 4'd7);
    check("loss_outs_zero", {data_out, ctrl_out, de_out}, '0);

    send_until_locked(TOK10, 40, n);
    check("relock_edge", n, LT + 2);

    // Asynchronous reset while locked, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_locked", {locked, bit_offset}, '0);
    check("async_rst_outs", {data_out, ctrl_out, de_out}, '0);

    // Random blanking/active traffic at a random phase.
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      s_shift = $urandom_range(0, 9);
      for (int line = 0; line < 14; line++) begin
        int nb, na;
        nb = $urandom_range(4, 16);
        na = $urandom_range(10, 90);
        for (int b = 0; b < nb; b++) begin
          case ($urandom_range(0, 3))
            0:       send(TOK00);
            1:       send(TOK01);
            2:       send(TOK10);
            default: send(TOK11);
          endcase
        end
        for (int a = 0; a < na; a++) send(10'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
